// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - memory-side responder: wait-state sequencing, req/ack handshake, tristate read-back
module ram_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] address_bus,
  inout  wire  [15:0] transfer_bus,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  output logic        o_ack,
  output logic        o_busy,
  output logic        o_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [3:0] WS_M1 = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t                  state_q;
  logic                    op_wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [15:0]             data_q;
  logic [15:0]             rdata_q;
  logic [3:0]              cnt_q;
  logic                    ack_q;
  logic                    busy_q;
  logic                    err_q;
  logic                    drive_q;

  logic [15:0]             mem [2**ADDR_WIDTH];

  logic                    one_req;
  logic                    both_req;
  logic                    any_req;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    idle_go_ack;
  logic                    wait_go_ack;
  logic                    acc_wr;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [15:0]             acc_data;
  logic                    unused_addr_hi;

  assign one_req        = i_mem_read ^ i_mem_write;
  assign both_req       = i_mem_read & i_mem_write;
  assign any_req        = i_mem_read | i_mem_write;
  assign req_addr       = address_bus[ADDR_WIDTH-1:0];
  assign unused_addr_hi = ^address_bus[15:ADDR_WIDTH];

  // With zero wait states the access happens on the accepting edge, straight from the bus.
  assign idle_go_ack = (state_q == S_IDLE) && one_req && (WAIT_STATES == 0);
  assign wait_go_ack = (state_q == S_WAIT) && any_req && (cnt_q == 4'd0);
  assign acc_wr      = (state_q == S_IDLE) ? i_mem_write  : op_wr_q;
  assign acc_addr    = (state_q == S_IDLE) ? req_addr     : addr_q;
  assign acc_data    = (state_q == S_IDLE) ? transfer_bus : data_q;

  assign o_ack        = ack_q;
  assign o_busy       = busy_q;
  assign o_err        = err_q;
  assign transfer_bus = drive_q ? rdata_q : 16'hzzzz;

  // Array is never reset; a reset edge blocks any pending commit.
  always_ff @(posedge i_clk) begin
    if (!i_rst && (idle_go_ack || wait_go_ack) && acc_wr) begin
      mem[acc_addr] <= acc_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      drive_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          err_q <= both_req;
          if (one_req) begin
            op_wr_q <= i_mem_write;
            addr_q  <= req_addr;
            if (i_mem_write) data_q <= transfer_bus;
            busy_q  <= 1'b1;
            if (WAIT_STATES == 0) begin
              state_q <= S_ACK;
              ack_q   <= 1'b1;
              drive_q <= i_mem_read;
              if (i_mem_read) rdata_q <= mem[req_addr];
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= WS_M1;
            end
          end
        end
        S_WAIT: begin
          if (!any_req) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == 4'd0) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            drive_q <= !op_wr_q;
            if (!op_wr_q) rdata_q <= mem[addr_q];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACK: begin
          if (!any_req) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            drive_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          drive_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - randomized bench for ram_responder at wait states 0, 1 and 3
module tb_ram_responder;

  logic        clk;
  logic        rst;
  logic [2:0]  rd, wr, oe;
  wire  [2:0]  ack, busy, err;
  logic [15:0] addr [3];
  logic [15:0] drv  [3];
  wire  [15:0] bus_obs [3];

  logic [15:0] mem_m [3][256];
  int          checks;
  int          errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Undriven bus reads back as all ones through the pull-up.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    wire [15:0] bus;
    pullup (bus);
    assign bus = oe[g] ? drv[g] : 16'hzzzz;
    assign bus_obs[g] = bus;
    ram_responder #(
      .ADDR_WIDTH (8),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .address_bus (addr[g]),
      .transfer_bus(bus),
      .i_mem_read  (rd[g]),
      .i_mem_write (wr[g]),
      .o_ack       (ack[g]),
      .o_busy      (busy[g]),
      .o_err       (err[g])
    );
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_op(input int k, input bit is_wr, input logic [15:0] a,
                       input logic [15:0] d, input bit rst_in_ack);
    int          n;
    logic [15:0] exp;
    exp = mem_m[k][a[7:0]];
    @(negedge clk);
    addr[k] = a; rd[k] = !is_wr; wr[k] = is_wr; oe[k] = is_wr; drv[k] = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack[k] && n < 40);
    chk("latency", n, ws_of(k) + 1);
    chk("busy_in_ack", busy[k], 1'b1);
    if (is_wr) begin
      mem_m[k][a[7:0]] = d;
      drv[k] = ~d;
    end else begin
      chk("rdata", bus_obs[k], exp);
    end
    if (rst_in_ack) begin
      rst = 1'b1;
      #1;
      chk("rst_ack", ack[k], 1'b0);
      chk("rst_bus", bus_obs[k], 16'hFFFF);
      chk("rst_busy", busy[k], 1'b0);
      @(negedge clk);
      rst = 1'b0;
      rd[k] = 1'b0; wr[k] = 1'b0; oe[k] = 1'b0;
    end else begin
      @(negedge clk);
      chk("ack_held", ack[k], 1'b1);
      rd[k] = 1'b0; wr[k] = 1'b0; oe[k] = 1'b0;
      #1;
      chk("ack_no_comb", ack[k], 1'b1);
      chk("bus_before_release", bus_obs[k], is_wr ? 16'hFFFF : exp);
    end
    @(negedge clk);
    chk("ack_released", ack[k], 1'b0);
    chk("busy_released", busy[k], 1'b0);
    chk("bus_released", bus_obs[k], 16'hFFFF);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rd = '0; wr = '0; oe = '0;
    for (int k = 0; k < 3; k++) begin
      addr[k] = '0;
      drv[k]  = '0;
      for (int i = 0; i < 256; i++) mem_m[k][i] = 16'h0000;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("reset_ack", ack[k], 1'b0);
      chk("reset_busy", busy[k], 1'b0);
      chk("reset_err", err[k], 1'b0);
      chk("reset_bus", bus_obs[k], 16'hFFFF);
    end

    do_op(1, 1'b0, 16'h0005, 16'h0000, 1'b0);
    do_op(1, 1'b1, 16'h0012, 16'hBEEF, 1'b0);
    do_op(1, 1'b0, 16'h0012, 16'h0000, 1'b0);
    do_op(1, 1'b0, 16'h0112, 16'h0000, 1'b0);

    // Conflicting requests: rejected every cycle, nothing latched.
    @(negedge clk);
    addr[1] = 16'h0012; rd[1] = 1'b1; wr[1] = 1'b1; oe[1] = 1'b1; drv[1] = 16'h5A5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("err_pulse", err[1], 1'b1);
      chk("err_busy", busy[1], 1'b0);
      chk("err_ack", ack[1], 1'b0);
    end
    rd[1] = 1'b0; wr[1] = 1'b0; oe[1] = 1'b0;
    #1;
    chk("err_bus", bus_obs[1], 16'hFFFF);
    @(negedge clk);
    chk("err_clear", err[1], 1'b0);
    do_op(1, 1'b0, 16'h0012, 16'h0000, 1'b0);

    // Write abandoned during WAIT.
    @(negedge clk);
    addr[2] = 16'h0020; wr[2] = 1'b1; oe[2] = 1'b1; drv[2] = 16'h1234;
    @(negedge clk);
    chk("abort_busy", busy[2], 1'b1);
    chk("abort_ack", ack[2], 1'b0);
    wr[2] = 1'b0; oe[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_idle_busy", busy[2], 1'b0);
      chk("abort_no_ack", ack[2], 1'b0);
    end
    do_op(2, 1'b0, 16'h0020, 16'h0000, 1'b0);

    // Reset during WAIT drops the write.
    @(negedge clk);
    addr[2] = 16'h0040; wr[2] = 1'b1; oe[2] = 1'b1; drv[2] = 16'h5555;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_wait_busy", busy[2], 1'b0);
    @(negedge clk);
    rst = 1'b0; wr[2] = 1'b0; oe[2] = 1'b0;
    do_op(2, 1'b0, 16'h0040, 16'h0000, 1'b0);

    do_op(1, 1'b0, 16'h0012, 16'h0000, 1'b1);
    do_op(1, 1'b0, 16'h0012, 16'h0000, 1'b0);

    do_op(0, 1'b1, 16'h0001, 16'h00FF, 1'b0);
    do_op(0, 1'b0, 16'h0001, 16'h0000, 1'b0);

    for (int i = 0; i < 60; i++) begin
      int          k;
      bit          w;
      logic [15:0] a;
      logic [15:0] d;
      k = $urandom_range(0, 2);
      w = 1'($urandom_range(0, 1));
      a = {8'($urandom), 5'b0, 3'($urandom)};
      d = 16'($urandom_range(0, 16'hFFFE));
      do_op(k, w, a, d, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
